// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops, plus an optional shift-add multiplier
// built only when MULTICYCLE_ALU_MULT_EN is defined (aluop 1000 otherwise yields 0).
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluop,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;

  logic [WIDTH-1:0] w_alu;
  logic             r_done;
  logic             r_zero;
  logic [WIDTH-1:0] r_result;

  // Signed compare is done directly, so SLT stays correct when a-b overflows
  always_comb begin
    w_alu = '0;
    case (aluop)
      OP_ADD:  w_alu = a + b;
      OP_SUB:  w_alu = a - b;
      OP_AND:  w_alu = a & b;
      OP_OR:   w_alu = a | b;
      OP_XOR:  w_alu = a ^ b;
      OP_NOR:  w_alu = ~(a | b);
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
      default: w_alu = '0;
    endcase
  end

  assign done   = r_done;
  assign result = r_result;
  assign zero   = r_zero;

`ifdef MULTICYCLE_ALU_MULT_EN
  localparam logic [3:0]    OP_MUL = 4'b1000;
  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state;
  logic             r_busy;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign busy       = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (aluop == OP_MUL) begin
              r_state  <= S_MUL;
              r_busy   <= 1'b1;
              r_mcand  <= a;
              r_mplier <= b;
              r_acc    <= '0;
              r_cnt    <= '0;
            end else begin
              r_result <= w_alu;
              r_zero   <= (w_alu == '0);
              r_done   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          // One multiplier bit per cycle; the last step's sum goes straight to result
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_acc_next;
            r_zero   <= (w_acc_next == '0);
          end
        end
      endcase
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_done <= start;
      if (start) begin
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: cycle-level reference model with a per-cycle
// compare, directed literal cases, and a randomized phase with occasional async resets.
module tb_multicycle_alu;

`ifdef MULTICYCLE_ALU_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  aluop = '0;
  logic        busy, done, zero;
  logic [31:0] result;

  logic        s8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  op8 = '0;
  logic        busy8, done8, zero8;
  logic [7:0]  res8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .aluop(aluop),
    .busy(busy), .done(done), .result(result), .zero(zero));

  multicycle_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(s8), .a(a8), .b(b8), .aluop(op8),
    .busy(busy8), .done(done8), .result(res8), .zero(zero8));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] prod;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    prod = 64'(x) * 64'(y);
    case (op)
      4'd0:  return x + y;
      4'd2:  return x - y;
      4'd4:  return x & y;
      4'd5:  return x | y;
      4'd6:  return x ^ y;
      4'd7:  return ~(x | y);
      4'd10: return (sx < sy) ? 32'd1 : 32'd0;
      4'd11: return (x < y) ? 32'd1 : 32'd0;
      4'd8:  return MULT_EN ? prod[31:0] : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Reference model: cycles remaining until a pending multiply completes
  int          m_left = 0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_zero = 1'b1;
  logic [31:0] m_res = '0, m_pend = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_zero = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_busy = 1'b0; m_res = m_pend; m_zero = (m_pend == 0);
        end
      end else if (start) begin
        if (MULT_EN && aluop == 4'd8) begin
          m_left = 32; m_busy = 1'b1; m_pend = ref_op(aluop, a, b);
        end else begin
          m_done = 1'b1; m_res = ref_op(aluop, a, b); m_zero = (m_res == 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("result", result, m_res);
    chk("zero", zero, m_zero);
  end

  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input bit poke, output int lat, output int nbusy);
    @(negedge clk);
    start = 1'b1; aluop = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0; lat = 1; nbusy = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      if (poke && lat == 5) begin
        start = 1'b1; aluop = 4'd0; a = 32'd7; b = 32'd9;
      end else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("done_seen", done, 1'b1);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] pick_op();
    logic [3:0] ops [14] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11,
                             4'd8, 4'd1, 4'd3, 4'd9, 4'd12, 4'd15};
    return ops[$urandom_range(0, 13)];
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, nb, ndone;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // ADD wraps to zero
    do_op(4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, lat, nb);
    chk("add_lat", lat, 1);
    chk("add_wrap_res", result, 32'd0);
    chk("add_wrap_zero", zero, 1'b1);

    do_op(4'd10, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, lat, nb);
    chk("slt_pos_neg", result, 32'd0);
    do_op(4'd11, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, lat, nb);
    chk("sltu_pos_neg", result, 32'd1);
    do_op(4'd10, 32'h8000_0000, 32'd1, 1'b0, lat, nb);
    chk("slt_min_one", result, 32'd1);

    // Multiply with an ignored start during busy
    do_op(4'd8, 32'h0001_0003, 32'h0002_0005, 1'b1, lat, nb);
    chk("mul_lat", lat, MULT_EN ? 33 : 1);
    chk("mul_busy_cycles", nb, MULT_EN ? 32 : 0);
    chk("mul_res", result, MULT_EN ? 32'h000B_000F : 32'd0);
    @(negedge clk);
    chk("mul_no_extra_done", done, 1'b0);

    // Reset mid-multiply aborts; outputs clear without a clock edge
    start = 1'b1; aluop = 4'd8; a = 32'h1234; b = 32'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", zero, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_result", result, 32'd0);
    do_op(4'd0, 32'd2, 32'd3, 1'b0, lat, nb);
    chk("add_after_abort", result, 32'd5);

    // 8-bit back-to-back single-cycle ops
    @(negedge clk);
    s8 = 1'b1; op8 = 4'd4; a8 = 8'hF0; b8 = 8'h3C;
    @(negedge clk);
    op8 = 4'd5;
    chk("w8_and_done", done8, 1'b1);
    chk("w8_and_res", res8, 8'h30);
    @(negedge clk);
    op8 = 4'd7;
    chk("w8_or_done", done8, 1'b1);
    chk("w8_or_res", res8, 8'hFC);
    @(negedge clk);
    s8 = 1'b0;
    chk("w8_nor_done", done8, 1'b1);
    chk("w8_nor_res", res8, 8'h03);
    @(negedge clk);
    chk("w8_idle_done", done8, 1'b0);

    // Randomized traffic, including starts while busy and async resets
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 96) == 0) begin
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rnd_rst_busy", busy, 1'b0);
        chk("rnd_rst_done", done, 1'b0);
        chk("rnd_rst_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
      end else begin
        start = ($urandom_range(0, 1) == 1);
        aluop = pick_op();
        a = pick_val();
        b = pick_val();
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
